uart_rx_deserializer: RTL and testbench

//  Serial-to-parallel UART receive stage: oversamples the async Rx line, frames start/data/parity/stop,
//  and presents each good byte as Rx_Data with a one-clock Data_Rdy pulse. Sits directly upstream of
//  the receive FIFO (drives its Rx_Data/Data_Rdy inputs); reports parity/framing errors separately.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_deserializer.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// Used by the baud tick generator and the receive deserializer.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // Ticks per bit time, and the tick that lands in the middle of the start bit.
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..BAUD_DIV-1 divider that pulses
// `tick` for one clk on each wrap. `restart` forces the divider back to 0 so the
// next tick phase is referenced to the caller's event (e.g. a detected start edge).
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   restart in  resynchronise divider to 0 (suppresses tick this cycle)
//   tick    out one-clk oversample strobe
module uart_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int              CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking (<=) so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive stage: synchronises the async Rx line, frames start/data/
// parity/stop at 16x oversampling and presents each good byte on Rx_Data with
// a one-clk Data_Rdy pulse. Parity and framing errors drop the frame and are
// reported as separate one-clk pulses.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   Rx_In      in   asynchronous serial line, idle high
//   Rx_Data    out  last good received word, held until next good frame
//   Data_Rdy   out  one-clk pulse, Rx_Data valid
//   Parity_Err out  one-clk pulse, frame dropped on parity mismatch
//   Frame_Err  out  one-clk pulse, frame dropped on low stop bit
//   Rx_Busy    out  high whenever the receiver is not IDLE
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 27,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx_In,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Rx_Busy
);

  localparam int   BW  = $clog2(DATA_BITS);
  localparam logic ODD = 1'(PARITY_ODD);

  rx_state_t            state, next_state;
  logic                 sync1, rxs;
  logic [3:0]           tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 tick, restart;
  logic                 shift_en, par_sample, stop_sample;
  logic                 mid_tick, bit_tick, last_bit;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Two-flop synchroniser; resets to the idle-high line level so reset release
  // never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= Rx_In;
      rxs   <= sync1;
    end
  end

  assign mid_tick = tick && (tick_cnt == 4'(MID_SAMPLE - 1));
  assign bit_tick = tick && (tick_cnt == 4'(OVERSAMPLE - 1));
  assign last_bit = (bit_idx == BW'(DATA_BITS - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first; a path that leaves a
  // signal unassigned would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (!rxs) next_state = START;
      START:     if (mid_tick) next_state = rxs ? IDLE : DATA;
      DATA:      if (bit_tick && last_bit) next_state = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (bit_tick) next_state = STOP;
      STOP:      if (bit_tick) next_state = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output / strobe decode.
  always_comb begin
    restart     = 1'b0;
    shift_en    = 1'b0;
    par_sample  = 1'b0;
    stop_sample = 1'b0;
    Rx_Busy     = (state != IDLE);
    unique case (state)
      IDLE:    restart     = !rxs;
      DATA:    shift_en    = bit_tick;
      PARITY:  par_sample  = bit_tick;
      STOP:    stop_sample = bit_tick;
      default: ;
    endcase
  end

  // Datapath: tick counter, shift register, parity accumulator, output pulses.
  // NOTE: the shift register is reset along with the control flops; it is only
  // a few bits and keeps Rx_Data deterministic after a mid-frame abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      perr       <= 1'b0;
      Rx_Data    <= '0;
      Data_Rdy   <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      Data_Rdy   <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;

      // Re-zero at the start-bit midpoint so every later 16th tick is mid-bit.
      if ((state == IDLE) || ((state == START) && mid_tick)) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end

      if (restart) begin
        bit_idx <= '0;
        perr    <= 1'b0;
      end

      // LSB arrives first, so shift in from the top.
      if (shift_en) begin
        shift   <= {rxs, shift[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end

      if (par_sample) begin
        perr <= (((^shift) ^ rxs) != ODD);
      end

      // A low stop bit wins over a parity mismatch.
      if (stop_sample) begin
        if (!rxs) begin
          Frame_Err <= 1'b1;
        end else if (perr) begin
          Parity_Err <= 1'b1;
        end else begin
          Rx_Data  <= shift;
          Data_Rdy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer (8 data bits, even parity,
// BAUD_DIV=1 so one bit is 16 clk). A frame-level model predicts which pulse
// each frame must produce and what Rx_Data must hold at that moment; a monitor
// records the pulses the DUT actually emits and the two lists are compared.
module tb_uart_rx_deserializer;

  localparam int DB       = 8;
  localparam int BD       = 1;
  localparam int BIT_CLKS = 16 * BD;
  localparam int PODD     = 0;
  localparam int LAT      = 2 + BD * (8 + 16 * (1 + DB + 1)) + 1;

  localparam int K_DATA = 1;
  localparam int K_PAR  = 2;
  localparam int K_FRM  = 3;
  localparam int K_MULT = 7;

  logic          clk;
  logic          rst;
  logic          Rx_In;
  logic [DB-1:0] Rx_Data;
  logic          Data_Rdy;
  logic          Parity_Err;
  logic          Frame_Err;
  logic          Rx_Busy;

  typedef struct {
    int            kind;
    logic [DB-1:0] data;
    int            at;
  } ev_t;

  ev_t           obs[$];
  ev_t           exp_q[$];
  logic [DB-1:0] last_good;
  int            cyc;
  int            frame_start;
  int            mon_n;
  int            checks;
  int            errors;

  uart_rx_deserializer #(
    .DATA_BITS  (DB),
    .BAUD_DIV   (BD),
    .PARITY_EN  (1),
    .PARITY_ODD (PODD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Rx_In      (Rx_In),
    .Rx_Data    (Rx_Data),
    .Data_Rdy   (Data_Rdy),
    .Parity_Err (Parity_Err),
    .Frame_Err  (Frame_Err),
    .Rx_Busy    (Rx_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: any cycle with a pulse becomes one observed event.
  always @(negedge clk) begin
    if (!rst) begin
      mon_n = int'(Data_Rdy) + int'(Parity_Err) + int'(Frame_Err);
      if (mon_n != 0) begin
        obs.push_back('{kind: (mon_n > 1) ? K_MULT :
                              Data_Rdy   ? K_DATA :
                              Parity_Err ? K_PAR  : K_FRM,
                        data: Rx_Data, at: cyc});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive_bit(input logic b);
    Rx_In = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    Rx_In = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  // Sends one frame and records what the receiver must report for it.
  task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input bit stop_v);
    logic p;
    p = (^d) ^ 1'(PODD);
    if (bad_par) p = ~p;
    frame_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop_v);
    if (!stop_v) begin
      exp_q.push_back('{kind: K_FRM, data: last_good, at: 0});
    end else if (bad_par) begin
      exp_q.push_back('{kind: K_PAR, data: last_good, at: 0});
    end else begin
      last_good = d;
      exp_q.push_back('{kind: K_DATA, data: d, at: 0});
    end
  endtask

  task automatic compare_events(input string tag);
    check($sformatf("%s_count", tag), obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_kind%0d", tag, i), obs[i].kind, exp_q[i].kind);
      check($sformatf("%s_data%0d", tag, i), 32'(obs[i].data), 32'(exp_q[i].data));
    end
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_good = '0;
    Rx_In     = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_data",   32'(Rx_Data), 0);
    check("rst_data_rdy",  32'(Data_Rdy), 0);
    check("rst_parity",    32'(Parity_Err), 0);
    check("rst_frame",     32'(Frame_Err), 0);
    check("rst_busy",      32'(Rx_Busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame, plus latency from falling edge to Data_Rdy.
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(2);
    check("a5_present", (obs.size() > 0), 1);
    if (obs.size() > 0) begin
      check("a5_latency", ((obs[0].at - frame_start) >= LAT - BD) &&
                          ((obs[0].at - frame_start) <= LAT + BD), 1);
    end
    compare_events("a5");
    check("a5_rx_data", 32'(Rx_Data), 32'h A5);

    // Parity error: frame dropped, Rx_Data held.
    send_frame(8'h3C, 1'b1, 1'b1);
    idle_bits(2);
    compare_events("3c_par");
    check("3c_rx_data", 32'(Rx_Data), 32'hA5);

    // Framing error with the line stuck low for 40 bits.
    send_frame(8'h55, 1'b0, 1'b0);
    Rx_In = 1'b0;
    repeat (39 * BIT_CLKS) @(negedge clk);
    check("brk_busy_low", 32'(Rx_Busy), 1);
    Rx_In = 1'b1;
    repeat (4) @(negedge clk);
    check("brk_busy_rel", 32'(Rx_Busy), 0);
    idle_bits(2);
    compare_events("55_frm");

    // Short low glitch on an idle line.
    Rx_In = 1'b0;
    repeat (4) @(negedge clk);
    Rx_In = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", 32'(Rx_Busy), 0);
    check("glitch_rx_data", 32'(Rx_Data), 32'hA5);
    compare_events("glitch");

    // Back-to-back frames with a single stop bit.
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle_bits(2);
    compare_events("b2b");

    // Reset in the middle of the data bits of 0x5A.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h5A >> i));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rx_data", 32'(Rx_Data), 0);
    check("mid_rst_data_rdy", 32'(Data_Rdy), 0);
    check("mid_rst_parity", 32'(Parity_Err), 0);
    check("mid_rst_frame", 32'(Frame_Err), 0);
    check("mid_rst_busy", 32'(Rx_Busy), 0);
    last_good = '0;
    Rx_In     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    compare_events("mid_rst");
    send_frame(8'h5A, 1'b0, 1'b1);
    idle_bits(2);
    compare_events("after_rst");

    // Randomised mix of good, parity-error and framing-error frames.
    for (int f = 0; f < 40; f++) begin
      logic [DB-1:0] d;
      int            r;
      bit            bad_par, bad_stop;
      d        = DB'($urandom);
      r        = $urandom_range(0, 9);
      bad_par  = (r < 2) || ((r == 2) && $urandom_range(0, 1) == 1);
      bad_stop = (r == 2);
      send_frame(d, bad_par, !bad_stop);
      if (bad_stop) idle_bits(2 + $urandom_range(0, 1));
      else          idle_bits($urandom_range(0, 2));
    end
    idle_bits(2);
    compare_events("rand");
    check("rand_rx_data", 32'(Rx_Data), 32'(last_good));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
